// File: rtl/i2s_codec_if.sv
`timescale 1ns/1ps
// i2s_codec_if: master-mode, full-duplex audio serial port.
// Generates BCLK/LRCK from i_clk, serialises one stereo DAC sample per frame
// and deserialises both ADC channels, in I2S or left-justified format.
module i2s_codec_if #(
    parameter int DATA_W    = 24,  // sample width, 8..32
    parameter int SLOT_W    = 32,  // BCLK periods per channel slot, >= DATA_W+1
    parameter int BCLK_HALF = 2    // i_clk cycles per BCLK half-period, >= 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_mode,
    input  logic              i_mute,
    input  logic [DATA_W-1:0] i_dac_l,
    input  logic [DATA_W-1:0] i_dac_r,
    output logic              o_sample_req,
    output logic [DATA_W-1:0] o_adc_l,
    output logic [DATA_W-1:0] o_adc_r,
    output logic              o_adc_valid,
    output logic              o_busy,
    output logic              o_bclk,
    output logic              o_lrck,
    output logic              o_dac_dat,
    input  logic              i_adc_dat
);

    localparam int KW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int HW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(SLOT_W - 1);
    localparam logic [KW-1:0] K_DW   = KW'(DATA_W);
    localparam logic [HW-1:0] H_LAST = HW'(BCLK_HALF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [HW-1:0]     hcnt;      // half-period counter
    logic [KW-1:0]     kcnt;      // bit index within the current slot
    logic              slot;      // 0 = left slot, 1 = right slot
    logic              bclk_q;
    logic              lrck_q;
    logic              mode_q;    // frame format, frozen for the whole frame
    logic              dac_q;
    logic [DATA_W-1:0] dac_sr;    // DAC word being shifted out, MSB first
    logic [DATA_W-1:0] dr_q;      // right DAC word waiting for its slot
    logic [DATA_W-1:0] adc_sr;    // ADC word being shifted in
    logic [DATA_W-1:0] cap_l;     // completed left ADC word
    logic [DATA_W-1:0] adc_l_q;
    logic [DATA_W-1:0] adc_r_q;

    logic              running;
    logic              tick;
    logic              fall;
    logic              rise;
    logic              last_bit;
    logic              slot_end;
    logic              frame_end;
    logic              start;
    logic [KW-1:0]     k_next;
    logic [DATA_W-1:0] dl_in;
    logic [DATA_W-1:0] dr_in;

    // True when bit index k carries sample data for the given frame format.
    function automatic logic in_window(input logic lj, input logic [KW-1:0] k);
        if (lj)
            return k < K_DW;
        return (k != '0) && (k <= K_DW);
    endfunction

    assign running   = (state != ST_IDLE);
    assign tick      = (hcnt == H_LAST);
    assign fall      = running && tick && bclk_q;
    assign rise      = running && tick && !bclk_q;
    assign last_bit  = slot && (kcnt == K_LAST);
    assign slot_end  = fall && !slot && (kcnt == K_LAST);
    assign frame_end = fall && last_bit;
    assign k_next    = kcnt + 1'b1;
    assign dl_in     = i_mute ? '0 : i_dac_l;
    assign dr_in     = i_mute ? '0 : i_dac_r;

    // NOTE: the frame-start decision is combinational so the DSP sees o_sample_req
    // in the same cycle its samples are taken; it is masked while i_rst is held.
    assign start = !i_rst && i_enable &&
                   ((state == ST_IDLE) || ((state == ST_RUN) && frame_end));

    assign o_sample_req = start;
    assign o_adc_valid  = frame_end;
    assign o_adc_l      = frame_end ? cap_l  : adc_l_q;
    assign o_adc_r      = frame_end ? adc_sr : adc_r_q;
    assign o_busy       = running;
    assign o_bclk       = bclk_q;
    assign o_lrck       = running ? lrck_q : ~i_mode;
    assign o_dac_dat    = dac_q;

    // Frame control: state, BCLK divider, bit/slot counters and LRCK.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // block samples the same pre-edge values regardless of block order.
        if (i_rst) begin
            state  <= ST_IDLE;
            hcnt   <= '0;
            kcnt   <= '0;
            slot   <= 1'b0;
            bclk_q <= 1'b1;
            lrck_q <= 1'b0;
            mode_q <= 1'b0;
        end else if (start) begin
            state  <= ST_RUN;
            mode_q <= i_mode;
            hcnt   <= '0;
            kcnt   <= '0;
            slot   <= 1'b0;
            bclk_q <= 1'b0;
            lrck_q <= i_mode;
        end else if (running) begin
            if (tick) begin
                hcnt   <= '0;
                bclk_q <= ~bclk_q;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            if ((state == ST_RUN) && !i_enable)
                state <= ST_DRAIN;
            if (fall) begin
                if (last_bit) begin
                    state  <= ST_IDLE;
                    bclk_q <= 1'b1;
                    kcnt   <= '0;
                    slot   <= 1'b0;
                end else if (kcnt == K_LAST) begin
                    kcnt   <= '0;
                    slot   <= 1'b1;
                    lrck_q <= ~mode_q;
                end else begin
                    kcnt <= k_next;
                end
            end
        end
    end

    // DAC serialiser: latch both words at frame start, present bits on falling edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dac_q  <= 1'b0;
            dac_sr <= '0;
            dr_q   <= '0;
        end else if (start) begin
            dr_q <= dr_in;
            if (i_mode) begin
                dac_q  <= dl_in[DATA_W-1];
                dac_sr <= dl_in << 1;
            end else begin
                dac_q  <= 1'b0;
                dac_sr <= dl_in;
            end
        end else if (fall) begin
            if (last_bit) begin
                dac_q <= 1'b0;
            end else if (slot_end) begin
                if (mode_q) begin
                    dac_q  <= dr_q[DATA_W-1];
                    dac_sr <= dr_q << 1;
                end else begin
                    dac_q  <= 1'b0;
                    dac_sr <= dr_q;
                end
            end else if (in_window(mode_q, k_next)) begin
                dac_q  <= dac_sr[DATA_W-1];
                dac_sr <= dac_sr << 1;
            end else begin
                dac_q <= 1'b0;
            end
        end
    end

    // ADC deserialiser: shift in on rising edges, publish both words at frame end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            adc_sr  <= '0;
            cap_l   <= '0;
            adc_l_q <= '0;
            adc_r_q <= '0;
        end else begin
            if (frame_end) begin
                adc_l_q <= cap_l;
                adc_r_q <= adc_sr;
            end
            if (start) begin
                adc_sr <= '0;
            end else if (slot_end) begin
                cap_l  <= adc_sr;
                adc_sr <= '0;
            end else if (rise && in_window(mode_q, kcnt)) begin
                adc_sr <= {adc_sr[DATA_W-2:0], i_adc_dat};
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_if.sv
`timescale 1ns/1ps
// Self-checking bench for i2s_codec_if with default parameters
// (DATA_W=24, SLOT_W=32, BCLK_HALF=2: 4-cycle BCLK, 256-cycle frame).
module tb_i2s_codec_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        mute = 1'b0;
    logic [23:0] dac_l = '0;
    logic [23:0] dac_r = '0;
    logic        loop_en = 1'b1;
    logic        ext_bit = 1'b0;
    logic        adc_dat;

    logic        sample_req;
    logic [23:0] adc_l;
    logic [23:0] adc_r;
    logic        adc_valid;
    logic        busy;
    logic        bclk;
    logic        lrck;
    logic        dac_dat;

    int n_checks = 0;
    int n_errors = 0;

    // Loopback or a constant level on the ADC input.
    assign adc_dat = loop_en ? dac_dat : ext_bit;

    always #5 clk = ~clk;

    i2s_codec_if dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_mode       (mode),
        .i_mute       (mute),
        .i_dac_l      (dac_l),
        .i_dac_r      (dac_r),
        .o_sample_req (sample_req),
        .o_adc_l      (adc_l),
        .o_adc_r      (adc_r),
        .o_adc_valid  (adc_valid),
        .o_busy       (busy),
        .o_bclk       (bclk),
        .o_lrck       (lrck),
        .o_dac_dat    (dac_dat),
        .i_adc_dat    (adc_dat)
    );

    typedef struct packed {
        logic        mode;   // 1 = left-justified
        logic        mute;
        logic        ext;    // 1 = ADC input tied high instead of loopback
        logic [23:0] dl;
        logic [23:0] dr;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
        @(negedge clk);
    endtask

    // One drained frame: enable for a single cycle, then expect one o_adc_valid.
    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  found;
        mode    = v.mode;
        mute    = v.mute;
        loop_en = !v.ext;
        ext_bit = v.ext;
        dac_l   = v.dl;
        dac_r   = v.dr;
        enable  = 1'b1;
        #1 check($sformatf("vec%0d_req", idx), sample_req, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        n = 1;
        found = 0;
        while (n < 300 && !found) begin
            if (adc_valid) found = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check($sformatf("vec%0d_valid_cycle", idx), n, 256);
        check($sformatf("vec%0d_adc_l", idx), adc_l, v.exp_l);
        check($sformatf("vec%0d_adc_r", idx), adc_r, v.exp_r);
        wait_idle($sformatf("vec%0d_idle", idx));
    endtask

    // Scratch state for the hand-written sequences.
    int first_req, second_req, req_cnt, first_valid, valid_cnt, valid_n;
    int last_rise, rises, bad_per, errs0, errs1, bad_adc, low_cnt, busy_cnt;
    int fr, b, k;
    logic prev_bclk, lrck_a, lrck_b, exp_bit;
    logic [23:0] got_l, got_r, word;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 24'h800001, 24'h123456, 24'h800001, 24'h123456};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 24'h800001, 24'hFEDCBA, 24'h800001, 24'hFEDCBA};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'h000000, 24'h000000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 24'h123456, 24'h654321, 24'hFFFFFF, 24'hFFFFFF};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};

        // ---------------- reset held with i_enable = 1 ----------------
        rst = 1'b1;
        enable = 1'b1;
        mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bclk", bclk, 1'b1);
        check("rst_lrck_i2s", lrck, 1'b1);
        check("rst_req", sample_req, 1'b0);
        check("rst_valid", adc_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dac", dac_dat, 1'b0);
        check("rst_adc_l", adc_l, 24'h0);
        low_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bclk !== 1'b1 || sample_req !== 1'b0) low_cnt++;
        end
        check("rst_no_toggle", low_cnt, 0);
        mode = 1'b1;
        #1 check("rst_lrck_lj", lrck, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // ---------------- LJ loopback, timing of req/valid/BCLK ----------------
        mode = 1'b1; mute = 1'b0; loop_en = 1'b1;
        dac_l = 24'hA5A5A5; dac_r = 24'h5A5A5A;
        enable = 1'b1;
        #1 check("lj_req0", sample_req, 1'b1);
        prev_bclk = bclk;
        first_req = -1; second_req = -1; req_cnt = 0;
        first_valid = -1; valid_cnt = 0;
        last_rise = -1; rises = 0; bad_per = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 2) lrck_a = lrck;
            if (n == 130) lrck_b = lrck;
            if (sample_req) begin
                if (req_cnt == 0) first_req = n;
                else if (req_cnt == 1) second_req = n;
                req_cnt++;
            end
            if (adc_valid) begin
                valid_cnt++;
                if (valid_cnt == 1) begin
                    first_valid = n;
                    got_l = adc_l;
                    got_r = adc_r;
                end
            end
            if (bclk && !prev_bclk) begin
                if (last_rise >= 0 && (n - last_rise) != 4) bad_per++;
                last_rise = n;
                rises++;
            end
            prev_bclk = bclk;
        end
        enable = 1'b0;
        check("lj_first_valid_cycle", first_valid, 256);
        check("lj_adc_l", got_l, 24'hA5A5A5);
        check("lj_adc_r", got_r, 24'h5A5A5A);
        check("lj_req_period1", first_req, 256);
        check("lj_req_period2", second_req, 512);
        check("lj_req_count", req_cnt, 2);
        check("lj_valid_count", valid_cnt, 2);
        check("lj_bclk_period", bad_per, 0);
        check("lj_bclk_rises", rises, 150);
        check("lj_lrck_left", lrck_a, 1'b1);
        check("lj_lrck_right", lrck_b, 1'b0);
        wait_idle("lj_idle");

        // ---------------- I2S bit placement ----------------
        mode = 1'b0; loop_en = 1'b1;
        dac_l = 24'h800001; dac_r = 24'h3C3C3C;
        enable = 1'b1;
        #1 check("i2s_req0", sample_req, 1'b1);
        valid_cnt = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) enable = 1'b0;
            if (n == 2) lrck_a = lrck;
            if (n == 130) lrck_b = lrck;
            if ((n % 4) == 2 && n < 128) begin
                k = (n - 2) / 4;
                exp_bit = (k == 1 || k == 24) ? 1'b1 : 1'b0;
                check($sformatf("i2s_bit%0d", k), dac_dat, exp_bit);
            end
            if (adc_valid) begin
                valid_cnt++;
                got_l = adc_l;
                got_r = adc_r;
            end
        end
        check("i2s_lrck_left", lrck_a, 1'b0);
        check("i2s_lrck_right", lrck_b, 1'b1);
        check("i2s_valid_count", valid_cnt, 1);
        check("i2s_adc_l", got_l, 24'h800001);
        check("i2s_adc_r", got_r, 24'h3C3C3C);
        wait_idle("i2s_idle");

        // ---------------- table-driven single frames ----------------
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // ---------------- mute raised mid-frame ----------------
        mode = 1'b1; mute = 1'b0; loop_en = 1'b0; ext_bit = 1'b1;
        dac_l = 24'hA5A5A5; dac_r = 24'h5A5A5A;
        enable = 1'b1;
        #1 check("mute_req0", sample_req, 1'b1);
        errs0 = 0; errs1 = 0; valid_cnt = 0; bad_adc = 0;
        for (int n = 1; n <= 520; n++) begin
            @(negedge clk);
            if (n == 10) mute = 1'b1;
            if (n == 513) begin
                enable = 1'b0;
                mute = 1'b0;
            end
            if ((n % 4) == 2 && n < 512) begin
                fr = (n - 2) / 256;
                b = ((n - 2) / 4) % 64;
                k = b % 32;
                word = (b >= 32) ? 24'h5A5A5A : 24'hA5A5A5;
                exp_bit = (k < 24) ? word[23 - k] : 1'b0;
                if (fr == 0 && dac_dat !== exp_bit) errs0++;
                if (fr == 1 && dac_dat !== 1'b0) errs1++;
            end
            if (adc_valid) begin
                valid_cnt++;
                if (adc_l !== 24'hFFFFFF || adc_r !== 24'hFFFFFF) bad_adc++;
            end
        end
        check("mute_frame1_data", errs0, 0);
        check("mute_frame2_silent", errs1, 0);
        check("mute_valid_count", valid_cnt, 2);
        check("mute_adc_unaffected", bad_adc, 0);
        wait_idle("mute_idle");
        loop_en = 1'b1; ext_bit = 1'b0;

        // ---------------- drain: i_enable dropped at b = 10 ----------------
        mode = 1'b1; mute = 1'b0;
        dac_l = 24'h123456; dac_r = 24'h654321;
        enable = 1'b1;
        #1 check("drain_req0", sample_req, 1'b1);
        valid_cnt = 0; valid_n = -1; low_cnt = 0; busy_cnt = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 41) enable = 1'b0;
            if (adc_valid) begin
                valid_cnt++;
                valid_n = n;
                got_l = adc_l;
                got_r = adc_r;
            end
            if (n > 258) begin
                if (bclk !== 1'b1) low_cnt++;
                if (busy !== 1'b0) busy_cnt++;
            end
        end
        check("drain_valid_count", valid_cnt, 1);
        check("drain_valid_cycle", valid_n, 256);
        check("drain_adc_l", got_l, 24'h123456);
        check("drain_adc_r", got_r, 24'h654321);
        check("drain_bclk_steady", low_cnt, 0);
        check("drain_not_busy", busy_cnt, 0);
        enable = 1'b1;
        #1 check("drain_restart_req", sample_req, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        check("drain_restart_busy", busy, 1'b1);
        wait_idle("drain_restart_idle");

        // ---------------- reset at b = 40, then restart ----------------
        mode = 1'b1; loop_en = 1'b1;
        dac_l = 24'h3C3C3C; dac_r = 24'hC3C3C3;
        enable = 1'b1;
        valid_cnt = 0;
        for (int n = 1; n <= 162; n++) begin
            @(negedge clk);
            if (adc_valid) valid_cnt++;
        end
        rst = 1'b1;
        #1;
        check("midrst_bclk", bclk, 1'b1);
        check("midrst_lrck", lrck, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dac", dac_dat, 1'b0);
        check("midrst_req", sample_req, 1'b0);
        check("midrst_adc_l", adc_l, 24'h0);
        repeat (4) begin
            @(negedge clk);
            if (adc_valid) valid_cnt++;
        end
        check("midrst_no_valid", valid_cnt, 0);
        rst = 1'b0;
        #1 check("midrst_restart_req", sample_req, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        valid_n = -1;
        for (int n = 1; n <= 300; n++) begin
            if (adc_valid && valid_n < 0) begin
                valid_n = n;
                got_l = adc_l;
                got_r = adc_r;
            end
            @(negedge clk);
        end
        check("midrst_valid_cycle", valid_n, 256);
        check("midrst_adc_l_after", got_l, 24'h3C3C3C);
        check("midrst_adc_r_after", got_r, 24'hC3C3C3);
        wait_idle("midrst_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
